// File: rtl/board_input_conditioner.sv
// ============================================================================
// Module     : board_input_conditioner
// Description: Synchronises and debounces asynchronous board inputs, with
//              optional per-channel inversion, edge pulses, sticky edge flags
//              and a level interrupt.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module board_input_conditioner #(
  parameter int               WIDTH           = 8,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 1000000,
  parameter logic [WIDTH-1:0] INVERT_MASK     = '0,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = '0,
  parameter int               CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk100,
  input  logic             cpu_reset,
  input  logic [WIDTH-1:0] pins_in,
  input  logic [WIDTH-1:0] evt_clear,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  output logic [WIDTH-1:0] stable_level,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] rise_flag,
  output logic [WIDTH-1:0] fall_flag,
  output logic             irq
);

  // Sync flops start at the pin level that maps onto RESET_LEVEL, so release
  // never looks like an edge.
  localparam logic [WIDTH-1:0] c_sync_rst = RESET_LEVEL ^ INVERT_MASK;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_COUNTING = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  w_sync_lvl;
  logic [WIDTH-1:0]                  r_rise_flag;
  logic [WIDTH-1:0]                  r_fall_flag;
  logic                              r_irq;

  always_ff @(posedge clk100 or negedge cpu_reset) begin
    if (!cpu_reset) begin
      r_sync <= {SYNC_STAGES{c_sync_rst}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pins_in};
    end
  end

  assign w_sync_lvl = r_sync[SYNC_STAGES-1] ^ INVERT_MASK;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_level;
    logic             w_level_nxt;
    logic             r_rise;
    logic             w_rise_nxt;
    logic             r_fall;
    logic             w_fall_nxt;
    logic             w_disagree;
    logic             w_at_last;

    assign w_disagree = w_sync_lvl[i] ^ r_level;
    assign w_at_last  = (r_cnt == c_cnt_last);

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_level_nxt = r_level;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      case (r_state)
        ST_IDLE: begin
          // A single-cycle debounce accepts straight from idle.
          if (w_disagree) begin
            if (w_at_last) begin
              w_level_nxt = w_sync_lvl[i];
              w_rise_nxt  = w_sync_lvl[i];
              w_fall_nxt  = ~w_sync_lvl[i];
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt   = c_cnt_one;
              w_state_nxt = ST_COUNTING;
            end
          end
        end
        ST_COUNTING: begin
          if (!w_disagree) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else if (w_at_last) begin
            w_level_nxt = w_sync_lvl[i];
            w_rise_nxt  = w_sync_lvl[i];
            w_fall_nxt  = ~w_sync_lvl[i];
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt   = r_cnt + c_cnt_one;
          end
        end
        default: begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end

    always_ff @(posedge clk100 or negedge cpu_reset) begin
      if (!cpu_reset) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_level <= RESET_LEVEL[i];
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_level <= w_level_nxt;
        r_rise  <= w_rise_nxt;
        r_fall  <= w_fall_nxt;
      end
    end

    assign stable_level[i] = r_level;
    assign rise_pulse[i]   = r_rise;
    assign fall_pulse[i]   = r_fall;
  end

  // A new pulse wins over a simultaneous clear.
  always_ff @(posedge clk100 or negedge cpu_reset) begin
    if (!cpu_reset) begin
      r_rise_flag <= '0;
      r_fall_flag <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_rise_flag <= (r_rise_flag & ~evt_clear) | rise_pulse;
      r_fall_flag <= (r_fall_flag & ~evt_clear) | fall_pulse;
      r_irq       <= |((r_rise_flag & rise_en) | (r_fall_flag & fall_en));
    end
  end

  assign rise_flag = r_rise_flag;
  assign fall_flag = r_fall_flag;
  assign irq       = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_board_input_conditioner.sv
// ============================================================================
// Module     : tb_board_input_conditioner
// Description: Scoreboard bench for board_input_conditioner, directed
//              scenarios followed by randomized traffic.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_board_input_conditioner;

  localparam int         WIDTH   = 4;
  localparam int         SYNC    = 2;
  localparam int         DEB     = 4;
  localparam logic [3:0] INV     = 4'b1000;
  localparam logic [3:0] RST_LVL = 4'b0000;

  logic       clk100    = 1'b0;
  logic       cpu_reset = 1'b0;
  logic [3:0] pins_in   = 4'b1000;
  logic [3:0] evt_clear = 4'b0000;
  logic [3:0] rise_en   = 4'b0000;
  logic [3:0] fall_en   = 4'b0000;
  logic [3:0] stable_level;
  logic [3:0] rise_pulse;
  logic [3:0] fall_pulse;
  logic [3:0] rise_flag;
  logic [3:0] fall_flag;
  logic       irq;

  board_input_conditioner #(
    .WIDTH          (WIDTH),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .INVERT_MASK    (INV),
    .RESET_LEVEL    (RST_LVL)
  ) dut (
    .clk100      (clk100),
    .cpu_reset   (cpu_reset),
    .pins_in     (pins_in),
    .evt_clear   (evt_clear),
    .rise_en     (rise_en),
    .fall_en     (fall_en),
    .stable_level(stable_level),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .rise_flag   (rise_flag),
    .fall_flag   (fall_flag),
    .irq         (irq)
  );

  always #5 clk100 = ~clk100;

  typedef struct packed {
    logic [3:0] stable;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] rflag;
    logic [3:0] fflag;
    logic       irq;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rise_cnt[WIDTH];
  int   fall_cnt[WIDTH];

  // Reference model: a level is accepted once the last DEB synchronised
  // samples since the previous acceptance all differ from the held level.
  logic [3:0] m_pipe[SYNC];
  logic       m_hist[WIDTH][$];
  logic [3:0] m_stable, m_rise, m_fall, m_rflag, m_fflag;
  logic       m_irq;

  task automatic model_step();
    logic [3:0] lvl;
    bit         all_diff;
    if (!cpu_reset) begin
      for (int k = 0; k < SYNC; k++) m_pipe[k] = RST_LVL ^ INV;
      m_stable = RST_LVL;
      m_rise   = '0;
      m_fall   = '0;
      m_rflag  = '0;
      m_fflag  = '0;
      m_irq    = 1'b0;
      for (int c = 0; c < WIDTH; c++) m_hist[c].delete();
    end else begin
      m_irq   = |((m_rflag & rise_en) | (m_fflag & fall_en));
      m_rflag = (m_rflag & ~evt_clear) | m_rise;
      m_fflag = (m_fflag & ~evt_clear) | m_fall;
      lvl     = m_pipe[SYNC-1] ^ INV;
      for (int c = 0; c < WIDTH; c++) begin
        m_rise[c] = 1'b0;
        m_fall[c] = 1'b0;
        m_hist[c].push_back(lvl[c]);
        if (m_hist[c].size() > DEB) void'(m_hist[c].pop_front());
        all_diff = (m_hist[c].size() == DEB);
        for (int j = 0; j < m_hist[c].size(); j++)
          if (m_hist[c][j] == m_stable[c]) all_diff = 1'b0;
        if (all_diff) begin
          m_stable[c] = lvl[c];
          m_rise[c]   = lvl[c];
          m_fall[c]   = ~lvl[c];
          m_hist[c].delete();
        end
      end
      for (int k = SYNC - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = pins_in;
    end
    sb_q.push_back({m_stable, m_rise, m_fall, m_rflag, m_fflag, m_irq});
  endtask

  initial begin
    forever begin
      @(posedge clk100);
      model_step();
    end
  end

  // Monitor: the DUT presents a full output set every cycle.
  initial begin
    exp_t e;
    exp_t a;
    for (int c = 0; c < WIDTH; c++) begin
      rise_cnt[c] = 0;
      fall_cnt[c] = 0;
    end
    forever begin
      @(negedge clk100);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a = {stable_level, rise_pulse, fall_pulse, rise_flag, fall_flag, irq};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs @%0t: got lvl=%b rp=%b fp=%b rf=%b ff=%b irq=%b, expected lvl=%b rp=%b fp=%b rf=%b ff=%b irq=%b",
                   $time, a.stable, a.rise, a.fall, a.rflag, a.fflag, a.irq,
                   e.stable, e.rise, e.fall, e.rflag, e.fflag, e.irq);
        end
      end
      for (int c = 0; c < WIDTH; c++) begin
        rise_cnt[c] += int'(rise_pulse[c]);
        fall_cnt[c] += int'(fall_pulse[c]);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk100);
    #1;
  endtask

  task automatic measure(input int ch, input int max, output int first_k, output int npulse);
    first_k = -1;
    npulse  = 0;
    for (int k = 1; k <= max; k++) begin
      step();
      if (rise_pulse[ch]) begin
        if (first_k < 0) first_k = k;
        npulse++;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_k, npulse, base, fk_flag, fk_irq;

    // Reset held with the inverted pin inactive.
    repeat (5) step();
    cpu_reset = 1'b1;
    base = rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3]
         + fall_cnt[0] + fall_cnt[1] + fall_cnt[2] + fall_cnt[3];
    repeat (20) step();
    check("reset_level", stable_level, 0);
    check("reset_rflag", rise_flag, 0);
    check("reset_fflag", fall_flag, 0);
    check("reset_no_pulse", rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3]
          + fall_cnt[0] + fall_cnt[1] + fall_cnt[2] + fall_cnt[3] - base, 0);

    // Clean rising edge on channel 0.
    rise_en = 4'b0001;
    pins_in[0] = 1'b1;
    first_k = -1; fk_flag = -1; fk_irq = -1; npulse = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (rise_pulse[0]) begin
        if (first_k < 0) first_k = k;
        npulse++;
      end
      if (rise_flag[0] && fk_flag < 0) fk_flag = k;
      if (irq && fk_irq < 0) fk_irq = k;
    end
    check("clean_pulse_latency", first_k, 6);
    check("clean_pulse_count", npulse, 1);
    check("clean_flag_latency", fk_flag, 7);
    check("clean_irq_latency", fk_irq, 8);

    // Bounce on channel 1: 3 high, 1 low, then held high.
    base = rise_cnt[1];
    pins_in[1] = 1'b1;
    repeat (3) step();
    pins_in[1] = 1'b0;
    step();
    pins_in[1] = 1'b1;
    measure(1, 12, first_k, npulse);
    check("bounce_latency", first_k, 6);
    check("bounce_total_pulses", rise_cnt[1] - base, 1);

    // Three-cycle glitch alone is rejected.
    pins_in[1] = 1'b0;
    repeat (10) step();
    base = rise_cnt[1];
    pins_in[1] = 1'b1;
    repeat (3) step();
    pins_in[1] = 1'b0;
    repeat (10) step();
    check("glitch_no_pulse", rise_cnt[1] - base, 0);

    // Inverted channel 3: pin 1->0 is a rising edge.
    pins_in[3] = 1'b0;
    measure(3, 12, first_k, npulse);
    check("invert_latency", first_k, 6);
    check("invert_count", npulse, 1);
    check("invert_level", stable_level[3], 1);

    // Clear race on channel 0.
    pins_in[0] = 1'b0;
    repeat (10) step();
    evt_clear = 4'b1111;
    step();
    evt_clear = 4'b0000;
    pins_in[0] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 6) begin
        check("race_pulse", rise_pulse[0], 1);
        evt_clear = 4'b0001;
      end
      if (k == 7) check("race_flag_kept", rise_flag[0], 1);
      if (k == 8) begin
        evt_clear = 4'b0000;
        check("clear_flag", rise_flag[0], 0);
        check("clear_irq_lag", irq, 1);
      end
      if (k == 9) check("clear_irq_drop", irq, 0);
    end

    // Reset in the middle of a count on channel 2.
    pins_in[2] = 1'b1;
    repeat (4) step();
    @(negedge clk100);
    #1;
    cpu_reset = 1'b0;
    #1;
    check("rst_mid_level", stable_level, RST_LVL);
    step();
    step();
    cpu_reset = 1'b1;
    measure(2, 12, first_k, npulse);
    check("rst_mid_latency", first_k, 6);
    check("rst_mid_count", npulse, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step();
      for (int b = 0; b < WIDTH; b++)
        if ($urandom_range(0, 7) == 0) pins_in[b] = ~pins_in[b];
      evt_clear = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 15) == 0) rise_en = 4'($urandom);
      if ($urandom_range(0, 15) == 0) fall_en = 4'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        @(negedge clk100);
        #1;
        cpu_reset = 1'b0;
        step();
        step();
        cpu_reset = 1'b1;
      end
    end

    evt_clear = 4'b0000;
    repeat (3) step();
    @(negedge clk100);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
